// File: rtl/ov7670_row_writer_pkg.sv
// Shared camera definitions: FSM states and the row-buffer address split.
package ov7670_row_writer_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_FRAME = 2'd0,
    ST_WAIT_ROW   = 2'd1,
    ST_ACTIVE     = 2'd2,
    ST_DROP       = 2'd3
  } state_t;

  localparam int BANK_DEPTH = 1024;
  localparam int COL_W      = $clog2(BANK_DEPTH);
  localparam int BANK_BIT   = COL_W;
  localparam int ADDR_W     = COL_W + 1;
  // Row length must be able to hold BANK_DEPTH itself
  localparam int LEN_W      = COL_W + 1;

endpackage

// File: rtl/ov7670_sync_edge.sv
// Camera input register stage plus registered edge detection of vsync/href.
module ov7670_sync_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  output logic       href_lvl,
  output logic [7:0] data,
  output logic       v_rise,
  output logic       v_fall,
  output logic       h_rise,
  output logic       h_fall
);

  logic       v_q_reg, h_q_reg, v_d_reg, h_d_reg;
  logic [7:0] d_q_reg, d_d_reg;
  logic       v_rise_reg, v_fall_reg, h_rise_reg, h_fall_reg;

  // Edge flags are aligned with the delayed copies, so level, byte and
  // edges presented downstream all describe the same camera sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_q_reg    <= 1'b0;
      h_q_reg    <= 1'b0;
      d_q_reg    <= 8'd0;
      v_d_reg    <= 1'b0;
      h_d_reg    <= 1'b0;
      d_d_reg    <= 8'd0;
      v_rise_reg <= 1'b0;
      v_fall_reg <= 1'b0;
      h_rise_reg <= 1'b0;
      h_fall_reg <= 1'b0;
    end else begin
      v_q_reg    <= cam_vsync;
      h_q_reg    <= cam_href;
      d_q_reg    <= cam_data;
      v_d_reg    <= v_q_reg;
      h_d_reg    <= h_q_reg;
      d_d_reg    <= d_q_reg;
      v_rise_reg <= v_q_reg & ~v_d_reg;
      v_fall_reg <= ~v_q_reg & v_d_reg;
      h_rise_reg <= h_q_reg & ~h_d_reg;
      h_fall_reg <= ~h_q_reg & h_d_reg;
    end
  end

  assign href_lvl = h_d_reg;
  assign data     = d_d_reg;
  assign v_rise   = v_rise_reg;
  assign v_fall   = v_fall_reg;
  assign h_rise   = h_rise_reg;
  assign h_fall   = h_fall_reg;

endmodule

// File: rtl/ov7670_row_writer.sv
// Pairs OV7670 RGB565 bytes into pixels and writes rows into a two-bank
// ping-pong row buffer, publishing each finished row to the reader.
module ov7670_row_writer
  import ov7670_row_writer_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  parameter int ROW_W     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic [ADDR_W-1:0] buf_ada,
  output logic [15:0]       buf_dina,
  output logic              buf_wrea,
  output logic              buf_cea,
  output logic              row_done,
  output logic              row_bank,
  output logic [LEN_W-1:0]  row_len,
  output logic [ROW_W-1:0]  row_num,
  input  logic [1:0]        bank_release,
  output logic [1:0]        bank_full,
  output logic              frame_start,
  output logic              row_dropped
);

  localparam logic [LEN_W-1:0] COL_LIMIT = LEN_W'(MAX_WIDTH);

  logic       href_lvl, v_rise, v_fall, h_rise, h_fall;
  logic [7:0] data;

  ov7670_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .cam_vsync(cam_vsync),
    .cam_href (cam_href),
    .cam_data (cam_data),
    .href_lvl (href_lvl),
    .data     (data),
    .v_rise   (v_rise),
    .v_fall   (v_fall),
    .h_rise   (h_rise),
    .h_fall   (h_fall)
  );

  state_t             state_reg, state_next;
  logic               toggle_reg, toggle_next;
  logic [7:0]         first_reg, first_next;
  logic [LEN_W-1:0]   col_reg, col_next;
  logic               bank_sel_reg, bank_sel_next;
  logic [ROW_W-1:0]   row_cnt_reg, row_cnt_next;
  logic [ADDR_W-1:0]  ada_reg, ada_next;
  logic [15:0]        dina_reg, dina_next;
  logic               wrea_reg, wrea_next;
  logic               row_done_reg, row_done_next;
  logic               row_bank_reg, row_bank_next;
  logic [LEN_W-1:0]   row_len_reg, row_len_next;
  logic [ROW_W-1:0]   row_num_reg, row_num_next;
  logic [1:0]         bank_full_reg, bank_full_next;
  logic [1:0]         bank_set;
  logic               frame_start_reg, frame_start_next;
  logic               row_dropped_reg, row_dropped_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_WAIT_FRAME;
      toggle_reg      <= 1'b0;
      first_reg       <= 8'd0;
      col_reg         <= '0;
      bank_sel_reg    <= 1'b0;
      row_cnt_reg     <= '0;
      ada_reg         <= '0;
      dina_reg        <= 16'd0;
      wrea_reg        <= 1'b0;
      row_done_reg    <= 1'b0;
      row_bank_reg    <= 1'b0;
      row_len_reg     <= '0;
      row_num_reg     <= '0;
      bank_full_reg   <= 2'b00;
      frame_start_reg <= 1'b0;
      row_dropped_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      toggle_reg      <= toggle_next;
      first_reg       <= first_next;
      col_reg         <= col_next;
      bank_sel_reg    <= bank_sel_next;
      row_cnt_reg     <= row_cnt_next;
      ada_reg         <= ada_next;
      dina_reg        <= dina_next;
      wrea_reg        <= wrea_next;
      row_done_reg    <= row_done_next;
      row_bank_reg    <= row_bank_next;
      row_len_reg     <= row_len_next;
      row_num_reg     <= row_num_next;
      bank_full_reg   <= bank_full_next;
      frame_start_reg <= frame_start_next;
      row_dropped_reg <= row_dropped_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    toggle_next      = toggle_reg;
    first_next       = first_reg;
    col_next         = col_reg;
    bank_sel_next    = bank_sel_reg;
    row_cnt_next     = row_cnt_reg;
    ada_next         = ada_reg;
    dina_next        = dina_reg;
    wrea_next        = 1'b0;
    row_done_next    = 1'b0;
    row_bank_next    = row_bank_reg;
    row_len_next     = row_len_reg;
    row_num_next     = row_num_reg;
    row_dropped_next = row_dropped_reg;
    frame_start_next = v_fall;
    bank_set         = 2'b00;

    // vsync rising aborts whatever row is in flight without publishing it
    if (v_rise) begin
      state_next = ST_WAIT_FRAME;
    end else begin
      case (state_reg)
        ST_WAIT_FRAME: begin
          if (v_fall) begin
            state_next   = ST_WAIT_ROW;
            row_cnt_next = '0;
          end
        end
        ST_WAIT_ROW: begin
          if (h_rise) begin
            // The byte sampled with the href edge is the row's first byte
            toggle_next = 1'b1;
            first_next  = data;
            col_next    = '0;
            if (!bank_full_reg[0]) begin
              bank_sel_next = 1'b0;
              state_next    = ST_ACTIVE;
            end else if (!bank_full_reg[1]) begin
              bank_sel_next = 1'b1;
              state_next    = ST_ACTIVE;
            end else begin
              state_next       = ST_DROP;
              row_dropped_next = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          if (h_fall) begin
            bank_set[bank_sel_reg] = 1'b1;
            row_done_next = 1'b1;
            row_bank_next = bank_sel_reg;
            row_len_next  = col_reg;
            row_num_next  = row_cnt_reg;
            row_cnt_next  = row_cnt_reg + ROW_W'(1);
            state_next    = ST_WAIT_ROW;
          end else if (href_lvl) begin
            if (!toggle_reg) begin
              toggle_next = 1'b1;
              first_next  = data;
            end else begin
              toggle_next = 1'b0;
              if (col_reg < COL_LIMIT) begin
                wrea_next = 1'b1;
                ada_next  = {bank_sel_reg, col_reg[COL_W-1:0]};
                dina_next = {first_reg, data};
                col_next  = col_reg + LEN_W'(1);
              end
            end
          end
        end
        ST_DROP: begin
          if (h_fall) begin
            row_cnt_next = row_cnt_reg + ROW_W'(1);
            state_next   = ST_WAIT_ROW;
          end
        end
        default: state_next = ST_WAIT_FRAME;
      endcase
    end

    // A publish in the same cycle as a release of that bank keeps it owned
    bank_full_next = (bank_full_reg & ~bank_release) | bank_set;
  end

  assign buf_ada     = ada_reg;
  assign buf_dina    = dina_reg;
  assign buf_wrea    = wrea_reg;
  assign buf_cea     = wrea_reg;
  assign row_done    = row_done_reg;
  assign row_bank    = row_bank_reg;
  assign row_len     = row_len_reg;
  assign row_num     = row_num_reg;
  assign bank_full   = bank_full_reg;
  assign frame_start = frame_start_reg;
  assign row_dropped = row_dropped_reg;

endmodule

// File: tb/tb_ov7670_row_writer.sv
// Scoreboard bench for ov7670_row_writer: directed rows, queued expectations.
module tb_ov7670_row_writer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic [10:0] buf_ada;
  logic [15:0] buf_dina;
  logic        buf_wrea, buf_cea, row_done, row_bank, frame_start, row_dropped;
  logic [10:0] row_len;
  logic [9:0]  row_num;
  logic [1:0]  bank_release = 2'b00;
  logic [1:0]  bank_full;

  typedef struct packed { logic [10:0] addr; logic [15:0] data; } wr_t;
  typedef struct packed { logic bank; logic [10:0] len; logic [9:0] num; } row_t;

  wr_t  exp_wr[$];
  row_t exp_row[$];
  int   checks = 0;
  int   errors = 0;
  int   fs_count = 0;
  int   exp_fs = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  ov7670_row_writer #(.MAX_WIDTH(640), .ROW_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .buf_ada     (buf_ada),
    .buf_dina    (buf_dina),
    .buf_wrea    (buf_wrea),
    .buf_cea     (buf_cea),
    .row_done    (row_done),
    .row_bank    (row_bank),
    .row_len     (row_len),
    .row_num     (row_num),
    .bank_release(bank_release),
    .bank_full   (bank_full),
    .frame_start (frame_start),
    .row_dropped (row_dropped)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard queues
  always @(negedge clk) begin
    if (mon_en) begin
      check("cea_eq_wrea", 32'(buf_cea), 32'(buf_wrea));
      if (buf_wrea === 1'b1) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %03h data %04h, expected no write", buf_ada, buf_dina);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          $display("write addr=%03h data=%04h", buf_ada, buf_dina);
          check("write_addr", 32'(buf_ada), 32'(e.addr));
          check("write_data", 32'(buf_dina), 32'(e.data));
        end
      end
      if (row_done === 1'b1) begin
        if (exp_row.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_row_done: bank %0d len %0d num %0d, expected none", row_bank, row_len, row_num);
        end else begin
          row_t r;
          r = exp_row.pop_front();
          $display("row_done bank=%0d len=%0d num=%0d", row_bank, row_len, row_num);
          check("row_bank", 32'(row_bank), 32'(r.bank));
          check("row_len", 32'(row_len), 32'(r.len));
          check("row_num", 32'(row_num), 32'(r.num));
        end
      end
      if (frame_start === 1'b1) fs_count++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    cam_vsync = 1'b1;
    tick(3);
    cam_vsync = 1'b0;
    exp_fs++;
    tick(5);
    check("frame_start_count", 32'(fs_count), 32'(exp_fs));
  endtask

  task automatic release_banks(input logic [1:0] m);
    bank_release = m;
    tick(1);
    bank_release = 2'b00;
    tick(2);
  endtask

  // Pushes the expected writes/publish, then drives nbytes bytes start, start+1, ...
  task automatic send_row(input int nbytes, input int start, input bit drop,
                          input bit bank, input int num);
    int npix;
    npix = nbytes / 2;
    if (npix > 640) npix = 640;
    if (!drop) begin
      for (int k = 0; k < npix; k++)
        exp_wr.push_back('{addr: {bank, 10'(k)},
                           data: {8'(start + 2*k), 8'(start + 2*k + 1)}});
      exp_row.push_back('{bank: bank, len: 11'(npix), num: 10'(num)});
    end
    for (int i = 0; i < nbytes; i++) begin
      cam_href = 1'b1;
      cam_data = 8'(start + i);
      tick(1);
    end
    cam_href = 1'b0;
    cam_data = 8'd0;
    tick(5);
  endtask

  initial begin
    tick(3);
    check("rst_buf_ada", 32'(buf_ada), 0);
    check("rst_buf_dina", 32'(buf_dina), 0);
    check("rst_buf_wrea", 32'(buf_wrea), 0);
    check("rst_buf_cea", 32'(buf_cea), 0);
    check("rst_row_done", 32'(row_done), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    check("rst_row_len", 32'(row_len), 0);
    check("rst_row_num", 32'(row_num), 0);
    check("rst_row_bank", 32'(row_bank), 0);
    check("rst_bank_full", 32'(bank_full), 0);
    check("rst_row_dropped", 32'(row_dropped), 0);
    reset = 1'b0;
    mon_en = 1'b1;
    tick(2);

    // Basic row, odd row into bank 1, then a dropped row
    new_frame();
    send_row(8, 8'h01, 1'b0, 1'b0, 0);
    check("bank_full_after_row0", 32'(bank_full), 32'b01);
    send_row(7, 8'h10, 1'b0, 1'b1, 1);
    check("bank_full_after_row1", 32'(bank_full), 32'b11);
    check("no_drop_yet", 32'(row_dropped), 0);
    send_row(6, 8'h30, 1'b1, 1'b0, 0);
    check("row_dropped_set", 32'(row_dropped), 1);
    check("bank_full_after_drop", 32'(bank_full), 32'b11);
    release_banks(2'b01);
    check("bank_full_after_rel0", 32'(bank_full), 32'b10);
    send_row(4, 8'h20, 1'b0, 1'b0, 3);
    release_banks(2'b11);
    check("bank_full_cleared", 32'(bank_full), 32'b00);

    // Release between rows of a new frame
    new_frame();
    send_row(4, 8'h30, 1'b0, 1'b0, 0);
    send_row(2, 8'h40, 1'b0, 1'b1, 1);
    release_banks(2'b01);
    send_row(4, 8'h50, 1'b0, 1'b0, 2);
    check("bank_full_release_test", 32'(bank_full), 32'b11);
    release_banks(2'b11);

    // Truncation, then a zero-length row
    new_frame();
    send_row(1500, 0, 1'b0, 1'b0, 0);
    send_row(1, 8'h77, 1'b0, 1'b1, 1);
    release_banks(2'b11);
    check("row_dropped_sticky", 32'(row_dropped), 1);

    // Abort: vsync rises mid-row
    for (int k = 0; k < 3; k++)
      exp_wr.push_back('{addr: 11'(k), data: {8'(8'h60 + 2*k), 8'(8'h61 + 2*k)}});
    for (int i = 0; i < 8; i++) begin
      cam_href = 1'b1;
      cam_data = 8'(8'h60 + i);
      if (i == 6) cam_vsync = 1'b1;
      tick(1);
    end
    cam_href = 1'b0;
    tick(6);
    check("abort_bank_full", 32'(bank_full), 32'b00);

    // Reset mid-row: only the first pixel's write escapes
    new_frame();
    send_row(4, 8'h70, 1'b0, 1'b0, 0);
    check("bank_full_before_reset", 32'(bank_full), 32'b01);
    exp_wr.push_back('{addr: 11'h400, data: 16'h8081});
    for (int i = 0; i < 4; i++) begin
      cam_href = 1'b1;
      cam_data = 8'(8'h80 + i);
      tick(1);
    end
    cam_data = 8'h84;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    cam_href = 1'b0;
    check("mid_rst_buf_ada", 32'(buf_ada), 0);
    check("mid_rst_buf_dina", 32'(buf_dina), 0);
    check("mid_rst_buf_wrea", 32'(buf_wrea), 0);
    check("mid_rst_row_len", 32'(row_len), 0);
    check("mid_rst_bank_full", 32'(bank_full), 0);
    check("mid_rst_row_dropped", 32'(row_dropped), 0);
    tick(6);

    check("pending_writes", 32'(exp_wr.size()), 0);
    check("pending_rows", 32'(exp_row.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
